// File: rtl/button_event_if.sv
// Button event bundle: debounced level in, decoded event pulses and held level out.
interface button_event_if;
  logic btn_level;
  logic evt_short;
  logic evt_double;
  logic evt_long;
  logic evt_repeat;
  logic btn_held;

  modport master (
    output btn_level,
    input  evt_short, evt_double, evt_long, evt_repeat, btn_held
  );

  modport slave (
    input  btn_level,
    output evt_short, evt_double, evt_long, evt_repeat, btn_held
  );
endinterface

// File: rtl/button_event_decoder.sv
// Decodes a debounced button into short / double / long / auto-repeat event pulses.
// Define BUTTON_EVENT_REPEAT_EN to enable auto-repeat pulses while held after a long press.
module button_event_decoder #(
  parameter int TICK_DIV     = 27000,
  parameter int LONG_TICKS   = 800,
  parameter int DOUBLE_TICKS = 250,
  parameter int REPEAT_TICKS = 100
) (
  input  logic           clk,
  input  logic           rst_n,
  button_event_if.slave  bus
);

  localparam int MAX_LD    = (LONG_TICKS > DOUBLE_TICKS) ? LONG_TICKS : DOUBLE_TICKS;
  localparam int MAX_TICKS = (MAX_LD > REPEAT_TICKS) ? MAX_LD : REPEAT_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);
  localparam int PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // state | meaning: IDLE released, PRESS1 first press, GAP waiting for second press,
  // PRESS2 second press, HELD long press qualified and still held
  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_GAP,
    S_PRESS2,
    S_HELD
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          held_q;
  logic          rise, fall, edge_any, tick;
  logic          reach_long, reach_double;
  logic          evt_short_q, evt_short_d;
  logic          evt_double_q, evt_double_d;
  logic          evt_long_q, evt_long_d;

  assign rise     = bus.btn_level & ~held_q;
  assign fall     = ~bus.btn_level & held_q;
  assign edge_any = rise | fall;
  assign tick     = (pre_q == PW'(TICK_DIV - 1));

  // Saturating increment; thresholds test the value the counter is about to take.
  assign cnt_inc      = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  assign reach_long   = tick && (cnt_inc >= CW'(LONG_TICKS));
  assign reach_double = tick && (cnt_inc >= CW'(DOUBLE_TICKS));

`ifdef BUTTON_EVENT_REPEAT_EN
  logic evt_repeat_q, evt_repeat_d;
  logic reach_repeat;

  assign reach_repeat   = tick && (cnt_inc >= CW'(REPEAT_TICKS));
  assign bus.evt_repeat = evt_repeat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) evt_repeat_q <= 1'b0;
    else        evt_repeat_q <= evt_repeat_d;
  end
`else
  assign bus.evt_repeat = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    evt_short_d  = 1'b0;
    evt_double_d = 1'b0;
    evt_long_d   = 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
    evt_repeat_d = 1'b0;
`endif
    if (edge_any || tick) pre_d = '0;
    else                  pre_d = pre_q + 1'b1;
    if (edge_any)  cnt_d = '0;
    else if (tick) cnt_d = cnt_inc;
    else           cnt_d = cnt_q;

    // Edge checks come first so a coincident threshold is suppressed.
    case (state_q)
      S_IDLE: begin
        if (rise) state_d = S_PRESS1;
      end
      S_PRESS1: begin
        if (fall) state_d = S_GAP;
        else if (reach_long) begin
          evt_long_d = 1'b1;
          cnt_d      = '0;
          state_d    = S_HELD;
        end
      end
      S_GAP: begin
        if (rise) state_d = S_PRESS2;
        else if (reach_double) begin
          evt_short_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_PRESS2: begin
        if (fall) begin
          evt_double_d = 1'b1;
          state_d      = S_IDLE;
        end else if (reach_long) begin
          evt_long_d = 1'b1;
          cnt_d      = '0;
          state_d    = S_HELD;
        end
      end
      S_HELD: begin
        if (fall) state_d = S_IDLE;
`ifdef BUTTON_EVENT_REPEAT_EN
        else if (reach_repeat) begin
          evt_repeat_d = 1'b1;
          cnt_d        = '0;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pre_q        <= '0;
      cnt_q        <= '0;
      held_q       <= 1'b0;
      evt_short_q  <= 1'b0;
      evt_double_q <= 1'b0;
      evt_long_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      cnt_q        <= cnt_d;
      held_q       <= bus.btn_level;
      evt_short_q  <= evt_short_d;
      evt_double_q <= evt_double_d;
      evt_long_q   <= evt_long_d;
    end
  end

  assign bus.evt_short  = evt_short_q;
  assign bus.evt_double = evt_double_q;
  assign bus.evt_long   = evt_long_q;
  assign bus.btn_held   = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with TICK_DIV=4, LONG=10, DOUBLE=5, REPEAT=3.
module tb_button_event_decoder;

`ifdef BUTTON_EVENT_REPEAT_EN
  localparam int REP_EN = 1;
`else
  localparam int REP_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  button_event_if bif ();

  button_event_decoder #(
    .TICK_DIV    (4),
    .LONG_TICKS  (10),
    .DOUBLE_TICKS(5),
    .REPEAT_TICKS(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_short, n_double, n_long, n_repeat, n_multi, t_first;
  int n_tests = 0;
  int n_fail  = 0;

  always @(negedge clk) begin
    int k;
    k = int'(bif.evt_short) + int'(bif.evt_double) + int'(bif.evt_long) + int'(bif.evt_repeat);
    if (k > 0 && t_first < 0) t_first = cyc;
    if (k > 1) n_multi = n_multi + 1;
    n_short  = n_short  + int'(bif.evt_short);
    n_double = n_double + int'(bif.evt_double);
    n_long   = n_long   + int'(bif.evt_long);
    n_repeat = n_repeat + int'(bif.evt_repeat);
  end

  task automatic clear_log();
    n_short = 0; n_double = 0; n_long = 0; n_repeat = 0; n_multi = 0; t_first = -1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    bif.btn_level = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int hi1, lo1, hi2, tail;
    int e_short, e_double, e_long, e_rep;
    int e_off;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int e;
    int exp_rep;

    // hi1 lo1 hi2 tail | short double long rep(if enabled) | first-event offset from rise
    vecs[0] = '{ 8, 30,  0,  0, 1, 0, 0, 0, 28};
    vecs[1] = '{ 8,  8,  8, 10, 0, 1, 0, 0, 24};
    vecs[2] = '{70, 20,  0,  0, 0, 0, 1, 2, 40};
    vecs[3] = '{ 8, 21,  8, 30, 2, 0, 0, 0, 28};
    vecs[4] = '{ 8, 20,  8, 10, 0, 1, 0, 0, 36};
    vecs[5] = '{ 8,  8, 50, 10, 0, 0, 1, 0, 56};
    vecs[6] = '{40, 30,  0,  0, 1, 0, 0, 0, 60};
    vecs[7] = '{41, 20,  0,  0, 0, 0, 1, 0, 40};

    clear_log();
    bif.btn_level = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {bif.evt_short, bif.evt_double, bif.evt_long, bif.evt_repeat, bif.btn_held}, 0);
    rst_n = 1'b1;
    hold(1'b0, 5);
    chk("reset_quiet_events", n_short + n_double + n_long + n_repeat, 0);

    hold(1'b1, 1);
    chk("btn_held_follows", int'(bif.btn_held), 1);
    hold(1'b0, 30);

    for (int i = 0; i < 8; i++) begin
      clear_log();
      e = cyc + 1;
      hold(1'b1, vecs[i].hi1);
      hold(1'b0, vecs[i].lo1);
      if (vecs[i].hi2 > 0) begin
        hold(1'b1, vecs[i].hi2);
        hold(1'b0, vecs[i].tail);
      end
      exp_rep = (REP_EN != 0) ? vecs[i].e_rep : 0;
      chk($sformatf("v%0d_short", i),  n_short,  vecs[i].e_short);
      chk($sformatf("v%0d_double", i), n_double, vecs[i].e_double);
      chk($sformatf("v%0d_long", i),   n_long,   vecs[i].e_long);
      chk($sformatf("v%0d_repeat", i), n_repeat, exp_rep);
      chk($sformatf("v%0d_first_off", i), t_first - e, vecs[i].e_off);
      chk($sformatf("v%0d_one_hot", i), n_multi, 0);
    end

    // Reset in the middle of a press discards it.
    clear_log();
    hold(1'b1, 20);
    rst_n = 1'b0;
    #1;
    chk("midpress_reset_held", int'(bif.btn_held), 0);
    chk("midpress_reset_evts", {bif.evt_short, bif.evt_double, bif.evt_long, bif.evt_repeat}, 0);
    hold(1'b0, 3);
    rst_n = 1'b1;
    hold(1'b0, 60);
    chk("midpress_no_events", n_short + n_double + n_long + n_repeat, 0);

    // Level high across reset release is seen as a rise on the first edge.
    clear_log();
    rst_n = 1'b0;
    hold(1'b1, 3);
    chk("reset_held_zero", int'(bif.btn_held), 0);
    rst_n = 1'b1;
    e = cyc + 1;
    hold(1'b1, 45);
    hold(1'b0, 20);
    chk("postreset_long", n_long, 1);
    chk("postreset_long_off", t_first - e, 40);
    chk("postreset_others", n_short + n_double + n_repeat, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
